// File: rtl/mem_axi_master_pkg.sv
// Shared codes for the MEM-stage AXI4-Lite load/store unit: funct3 sizes, AXI
// response codes, FSM state encoding and the byte-size mask helper.
package mem_axi_master_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // funct3[1:0] encodes log2 of the access size in bytes
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_axi_master_if.sv
// AXI4-Lite bus, 64-bit data, between the MEM-stage master and a memory slave.
// Valids are driven by the source side and held until the matching ready.
interface mem_axi_master_if #(
  parameter int AW = 32
);
  logic [AW-1:0] m_awaddr;
  logic          m_awvalid;
  logic          m_awready;
  logic [63:0]   m_wdata;
  logic [7:0]    m_wstrb;
  logic          m_wvalid;
  logic          m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid;
  logic          m_bready;
  logic [AW-1:0] m_araddr;
  logic          m_arvalid;
  logic          m_arready;
  logic [63:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rvalid;
  logic          m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/mem_axi_master_lsu_align.sv
// Combinational lane steering: store replicate/strobe, load extract/extend, misalignment.
// Zero latency, no handshake; purely a function of funct3 and the low address bits.
module lsu_align
  import mem_axi_master_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_lane,
  input  logic [63:0] i_wsrc,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_ldata,
  output logic        o_misal
);

  logic [1:0]  w_size;
  logic [63:0] w_shift;

  assign w_size = i_funct3[1:0];

  always_comb begin
    o_wdata = i_wsrc;
    o_ldata = 64'd0;
    o_misal = 1'b0;
    o_wstrb = size_mask(w_size) << i_lane;
    w_shift = i_rdata >> {i_lane, 3'b000};
    // funct3[2] set means zero-extend (LBU/LHU/LWU)
    case (w_size)
      2'd0: begin
        o_wdata = {8{i_wsrc[7:0]}};
        o_ldata = i_funct3[2] ? {56'd0, w_shift[7:0]} : {{56{w_shift[7]}}, w_shift[7:0]};
      end
      2'd1: begin
        o_wdata = {4{i_wsrc[15:0]}};
        o_ldata = i_funct3[2] ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
        o_misal = i_lane[0];
      end
      2'd2: begin
        o_wdata = {2{i_wsrc[31:0]}};
        o_ldata = i_funct3[2] ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
        o_misal = |i_lane[1:0];
      end
      default: begin
        o_wdata = i_wsrc;
        o_ldata = w_shift;
        o_misal = |i_lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_axi_master.sv
// MEM-stage load/store unit: one AXI4-Lite transaction per request, holding EX/MEM via mem_en_o.
// Latency 1 cycle for non-memory ops, 3+ for memory ops; stalls on any missing ready/valid.
module mem_axi_master
  import mem_axi_master_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rd_addr_i,
  input  logic [63:0]      rd_data_i,
  input  logic             rd_wen_i,
  input  logic             read_ram_i,
  input  logic             write_ram_i,
  input  logic [31:0]      inst_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [63:0]      op2_i,
  output logic             mem_en_o,
  output logic [4:0]       rd_addr_o,
  output logic [63:0]      rd_data_o,
  output logic             rd_wen_o,
  output logic             err_o,
  mem_axi_master_if.master m_axi
);

  state_t        r_state, w_next;
  logic          r_arvalid, r_awvalid, r_wvalid, r_rd_wen, r_err;
  logic [AW-1:0] r_araddr, r_awaddr;
  logic [63:0]   r_wdata, r_rd_data;
  logic [7:0]    r_wstrb;
  logic [4:0]    r_rd_addr;
  logic          w_req, w_misal, w_aw_ok, w_w_ok, w_unused;
  logic [63:0]   w_wdata, w_ldata;
  logic [7:0]    w_wstrb;

  lsu_align u_align (
    .i_funct3 (inst_i[14:12]),
    .i_lane   (addr_i[2:0]),
    .i_wsrc   (op2_i),
    .i_rdata  (m_axi.m_rdata),
    .o_wdata  (w_wdata),
    .o_wstrb  (w_wstrb),
    .o_ldata  (w_ldata),
    .o_misal  (w_misal)
  );

  assign w_unused = ^{inst_i[31:15], inst_i[11:0]};
  assign w_req    = read_ram_i | write_ram_i;
  assign w_aw_ok  = ~r_awvalid | m_axi.m_awready;
  assign w_w_ok   = ~r_wvalid | m_axi.m_wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = w_misal ? S_DONE : (read_ram_i ? S_RADDR : S_WREQ);
      S_RADDR: if (m_axi.m_arready) w_next = S_RDATA;
      S_RDATA: if (m_axi.m_rvalid) w_next = S_DONE;
      S_WREQ:  if (w_aw_ok && w_w_ok) w_next = S_WRESP;
      S_WRESP: if (m_axi.m_bvalid) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en_o       = 1'b0;
    m_axi.m_rready = 1'b0;
    m_axi.m_bready = 1'b0;
    case (r_state)
      S_IDLE:  mem_en_o = w_req;
      S_RADDR: mem_en_o = 1'b1;
      S_RDATA: begin mem_en_o = 1'b1; m_axi.m_rready = 1'b1; end
      S_WREQ:  mem_en_o = 1'b1;
      S_WRESP: begin mem_en_o = 1'b1; m_axi.m_bready = 1'b1; end
      default: mem_en_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_wdata   <= 64'd0;
      r_wstrb   <= 8'd0;
      r_rd_addr <= 5'd0;
      r_rd_data <= 64'd0;
      r_rd_wen  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_req) begin
            r_rd_addr <= rd_addr_i;
            r_rd_data <= rd_data_i;
            r_rd_wen  <= rd_wen_i;
          end else if (w_misal) begin
            r_rd_wen <= 1'b0;
            r_err    <= 1'b1;
          end else if (read_ram_i) begin
            r_arvalid <= 1'b1;
            r_araddr  <= addr_i;
          end else begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= addr_i;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
          end
        end
        S_RADDR: if (m_axi.m_arready) r_arvalid <= 1'b0;
        S_RDATA: begin
          if (m_axi.m_rvalid) begin
            r_rd_addr <= rd_addr_i;
            r_rd_data <= w_ldata;
            r_rd_wen  <= (m_axi.m_rresp == RESP_OKAY) ? rd_wen_i : 1'b0;
            r_err     <= (m_axi.m_rresp != RESP_OKAY);
          end
        end
        S_WREQ: begin
          if (m_axi.m_awready) r_awvalid <= 1'b0;
          if (m_axi.m_wready)  r_wvalid  <= 1'b0;
        end
        S_WRESP: begin
          if (m_axi.m_bvalid) begin
            r_rd_wen <= 1'b0;
            r_err    <= (m_axi.m_bresp != RESP_OKAY);
          end
        end
        default: r_rd_wen <= 1'b0;
      endcase
    end
  end

  assign m_axi.m_arvalid = r_arvalid;
  assign m_axi.m_araddr  = r_araddr;
  assign m_axi.m_awvalid = r_awvalid;
  assign m_axi.m_awaddr  = r_awaddr;
  assign m_axi.m_wvalid  = r_wvalid;
  assign m_axi.m_wdata   = r_wdata;
  assign m_axi.m_wstrb   = r_wstrb;
  assign rd_addr_o       = r_rd_addr;
  assign rd_data_o       = r_rd_data;
  assign rd_wen_o        = r_rd_wen;
  assign err_o           = r_err;

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed plus random bench for mem_axi_master with a byte-level memory reference model.
module tb_mem_axi_master;
  import mem_axi_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic [63:0] rd_data_i = '0;
  logic        rd_wen_i = 1'b0;
  logic        read_ram_i = 1'b0;
  logic        write_ram_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] addr_i = '0;
  logic [63:0] op2_i = '0;
  logic        mem_en_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;
  logic        rd_wen_o;
  logic        err_o;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  mem [0:127];

  mem_axi_master_if #(.AW(32)) axi ();

  mem_axi_master #(.AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (rd_addr_i),
    .rd_data_i   (rd_data_i),
    .rd_wen_i    (rd_wen_i),
    .read_ram_i  (read_ram_i),
    .write_ram_i (write_ram_i),
    .inst_i      (inst_i),
    .addr_i      (addr_i),
    .op2_i       (op2_i),
    .mem_en_o    (mem_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o),
    .err_o       (err_o),
    .m_axi       (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected load result: gather the addressed bytes, then extend to 64 bits.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [2:0] lane,
                                           input logic [2:0] f3);
    int n = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(int'(lane) + i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] lane, input logic [2:0] f3);
    logic [7:0] s = '0;
    for (int i = 0; i < (1 << f3[1:0]); i++) s[int'(lane) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] byte_mask(input logic [7:0] strb);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (strb[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] ref_wbytes(input logic [63:0] op2, input logic [2:0] lane,
                                             input logic [2:0] f3);
    logic [63:0] w = '0;
    for (int i = 0; i < (1 << f3[1:0]); i++) w[8*(int'(lane) + i) +: 8] = op2[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] word_at(input int w);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[w*8 + i];
    return v;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] op2, input logic [4:0] rda, input logic wen);
    read_ram_i  = rd;
    write_ram_i = wr;
    inst_i      = $urandom;
    inst_i[14:12] = f3;
    addr_i      = a;
    op2_i       = op2;
    rd_addr_i   = rda;
    rd_data_i   = {$urandom, $urandom};
    rd_wen_i    = wen;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [63:0] word,
                         input int ar_dly, input int r_dly, input logic [1:0] resp,
                         input logic [4:0] rda, input logic wen, input string tag);
    logic ok = (resp == RESP_OKAY);
    @(negedge clk);
    issue(1'b1, 1'($urandom), f3, a, {$urandom, $urandom}, rda, wen);
    #1 chk({tag, ".mem_en_issue"}, 64'(mem_en_o), 64'd1);
    chk({tag, ".err_idle"}, 64'(err_o), 64'd0);
    for (int c = 0; c <= ar_dly; c++) begin
      @(negedge clk);
      axi.m_arready = (c == ar_dly);
      #1 chk({tag, ".arvalid"}, 64'(axi.m_arvalid), 64'd1);
      chk({tag, ".araddr"}, 64'(axi.m_araddr), 64'(a));
      chk({tag, ".no_aw"}, 64'({axi.m_awvalid, axi.m_wvalid}), 64'd0);
    end
    for (int c = 0; c <= r_dly; c++) begin
      @(negedge clk);
      axi.m_arready = 1'b0;
      axi.m_rvalid  = (c == r_dly);
      axi.m_rdata   = (c == r_dly) ? word : {$urandom, $urandom};
      axi.m_rresp   = resp;
      #1 chk({tag, ".rready"}, 64'(axi.m_rready), 64'd1);
      chk({tag, ".ar_dropped"}, 64'(axi.m_arvalid), 64'd0);
      chk({tag, ".mem_en_hold"}, 64'(mem_en_o), 64'd1);
    end
    @(negedge clk);
    axi.m_rvalid = 1'b0;
    #1 chk({tag, ".mem_en_done"}, 64'(mem_en_o), 64'd0);
    chk({tag, ".rd_data"}, rd_data_o, ref_load(word, a[2:0], f3));
    chk({tag, ".rd_addr"}, 64'(rd_addr_o), 64'(rda));
    chk({tag, ".rd_wen"}, 64'(rd_wen_o), 64'(ok & wen));
    chk({tag, ".err"}, 64'(err_o), 64'(!ok));
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [63:0] op2,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] resp, input string tag);
    logic [7:0] es = ref_strb(a[2:0], f3);
    int last = (aw_dly > w_dly) ? aw_dly : w_dly;
    @(negedge clk);
    issue(1'b0, 1'b1, f3, a, op2, 5'($urandom), 1'b1);
    #1 chk({tag, ".mem_en_issue"}, 64'(mem_en_o), 64'd1);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      axi.m_awready = (c == aw_dly);
      axi.m_wready  = (c == w_dly);
      #1 chk({tag, ".awvalid"}, 64'(axi.m_awvalid), 64'(c <= aw_dly));
      chk({tag, ".wvalid"}, 64'(axi.m_wvalid), 64'(c <= w_dly));
      chk({tag, ".awaddr"}, 64'(axi.m_awaddr), 64'(a));
      chk({tag, ".wstrb"}, 64'(axi.m_wstrb), 64'(es));
      chk({tag, ".wdata"}, axi.m_wdata & byte_mask(es), ref_wbytes(op2, a[2:0], f3));
      chk({tag, ".no_ar"}, 64'(axi.m_arvalid), 64'd0);
    end
    for (int c = 0; c <= b_dly; c++) begin
      @(negedge clk);
      axi.m_awready = 1'b0;
      axi.m_wready  = 1'b0;
      axi.m_bvalid  = (c == b_dly);
      axi.m_bresp   = resp;
      #1 chk({tag, ".bready"}, 64'(axi.m_bready), 64'd1);
      chk({tag, ".aw_w_dropped"}, 64'({axi.m_awvalid, axi.m_wvalid}), 64'd0);
      chk({tag, ".mem_en_hold"}, 64'(mem_en_o), 64'd1);
    end
    @(negedge clk);
    axi.m_bvalid = 1'b0;
    #1 chk({tag, ".mem_en_done"}, 64'(mem_en_o), 64'd0);
    chk({tag, ".rd_wen"}, 64'(rd_wen_o), 64'd0);
    chk({tag, ".err"}, 64'(err_o), 64'(resp != RESP_OKAY));
    chk({tag, ".b_once"}, 64'(axi.m_bready), 64'd0);
  endtask

  task automatic do_misal(input logic [31:0] a, input logic [2:0] f3, input logic st, input string tag);
    @(negedge clk);
    issue(!st, st, f3, a, {$urandom, $urandom}, 5'd3, 1'b1);
    #1 chk({tag, ".mem_en_issue"}, 64'(mem_en_o), 64'd1);
    @(negedge clk);
    #1 chk({tag, ".mem_en_done"}, 64'(mem_en_o), 64'd0);
    chk({tag, ".err"}, 64'(err_o), 64'd1);
    chk({tag, ".rd_wen"}, 64'(rd_wen_o), 64'd0);
    chk({tag, ".no_valid"}, 64'({axi.m_arvalid, axi.m_awvalid, axi.m_wvalid}), 64'd0);
  endtask

  task automatic alu_op(input logic [4:0] rda, input logic [63:0] d, input logic wen, input string tag);
    @(negedge clk);
    issue(1'b0, 1'b0, 3'd0, 32'($urandom), 64'd0, rda, wen);
    rd_data_i = d;
    #1 chk({tag, ".mem_en0"}, 64'(mem_en_o), 64'd0);
    @(negedge clk);
    #1 chk({tag, ".mem_en1"}, 64'(mem_en_o), 64'd0);
    chk({tag, ".rd_addr"}, 64'(rd_addr_o), 64'(rda));
    chk({tag, ".rd_data"}, rd_data_o, d);
    chk({tag, ".rd_wen"}, 64'(rd_wen_o), 64'(wen));
  endtask

  task automatic idle_chk(input logic exp_wen, input string tag);
    @(negedge clk);
    read_ram_i  = 1'b0;
    write_ram_i = 1'b0;
    #1 chk({tag, ".mem_en"}, 64'(mem_en_o), 64'd0);
    chk({tag, ".err"}, 64'(err_o), 64'd0);
    chk({tag, ".rd_wen"}, 64'(rd_wen_o), 64'(exp_wen));
    chk({tag, ".no_valid"}, 64'({axi.m_arvalid, axi.m_awvalid, axi.m_wvalid}), 64'd0);
  endtask

  initial begin
    int op, w, n, lane;
    logic [2:0]  f3;
    logic [1:0]  resp;
    logic [63:0] d;
    axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = RESP_OKAY;
    axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rdata = '0; axi.m_rresp = RESP_OKAY;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

    @(negedge clk);
    #1 chk("rst.valids", 64'({axi.m_arvalid, axi.m_awvalid, axi.m_wvalid}), 64'd0);
    chk("rst.readies", 64'({axi.m_rready, axi.m_bready}), 64'd0);
    chk("rst.addrs", {axi.m_awaddr, axi.m_araddr}, 64'd0);
    chk("rst.wdata", axi.m_wdata, 64'd0);
    chk("rst.wstrb", 64'(axi.m_wstrb), 64'd0);
    chk("rst.rd", 64'({rd_addr_o, rd_wen_o, err_o}), 64'd0);
    chk("rst.rd_data", rd_data_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    alu_op(5'd5, 64'h1234, 1'b1, "alu");
    do_load(32'h8000_0003, F3_LB, 64'h0000_0000_8000_0000, 2, 0, RESP_OKAY, 5'd7, 1'b1, "lb");
    idle_chk(1'b0, "lb.after");
    do_store(32'h1006, F3_SH, 64'hBEEF, 0, 3, 1, RESP_OKAY, "sh");
    idle_chk(1'b0, "sh.after");
    do_load(32'h1008, F3_LD, 64'h0123_4567_89AB_CDEF, 0, 1, RESP_SLVERR, 5'd9, 1'b1, "ld_err");
    idle_chk(1'b0, "ld_err.after");
    do_misal(32'h1002, F3_SW, 1'b1, "sw_mis");
    idle_chk(1'b0, "sw_mis.after");
    do_misal(32'h1005, F3_LHU, 1'b0, "lhu_mis");
    idle_chk(1'b0, "lhu_mis.after");

    // Reset while the read data phase is open
    @(negedge clk);
    issue(1'b1, 1'b0, F3_LW, 32'h1010, 64'd0, 5'd4, 1'b1);
    @(negedge clk);
    axi.m_arready = 1'b1;
    @(negedge clk);
    axi.m_arready = 1'b0;
    #1 chk("rstmid.in_rdata", 64'(axi.m_rready), 64'd1);
    rst = 1'b0;
    #1 chk("rstmid.rready", 64'(axi.m_rready), 64'd0);
    chk("rstmid.valids", 64'({axi.m_arvalid, axi.m_awvalid, axi.m_wvalid, axi.m_bready}), 64'd0);
    chk("rstmid.rd", 64'({rd_addr_o, rd_wen_o, err_o}), 64'd0);
    chk("rstmid.rd_data", rd_data_o, 64'd0);
    chk("rstmid.araddr", 64'(axi.m_araddr), 64'd0);
    read_ram_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_load(32'h1010, F3_LW, 64'h1111_2222_F333_4444, 0, 0, RESP_OKAY, 5'd4, 1'b1, "lw_post_rst");

    // Random back-to-back traffic against the byte memory model
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 3);
      w  = $urandom_range(0, 15);
      resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : RESP_OKAY;
      if (op == 0) begin
        d = {$urandom, $urandom};
        alu_op(5'($urandom), d, 1'($urandom), "rnd_alu");
      end else if (op <= 2) begin
        f3   = 3'($urandom_range(0, 6));
        n    = 1 << f3[1:0];
        lane = n * $urandom_range(0, 8 / n - 1);
        do_load(32'(32'h2000 + w * 8 + lane), f3, word_at(w), $urandom_range(0, 3),
                $urandom_range(0, 3), resp, 5'($urandom), 1'($urandom), "rnd_ld");
      end else begin
        f3   = 3'($urandom_range(0, 3));
        n    = 1 << f3[1:0];
        lane = n * $urandom_range(0, 8 / n - 1);
        d    = {$urandom, $urandom};
        do_store(32'(32'h2000 + w * 8 + lane), f3, d, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), resp, "rnd_st");
        if (resp == RESP_OKAY)
          for (int i = 0; i < n; i++) mem[w * 8 + lane + i] = d[8*i +: 8];
      end
    end
    idle_chk(rd_wen_o, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
